std_log2_pipe: RTL

Multi-cycle unsigned binary logarithm: the inverse operation to the exponential primitive in the unsigned bitnum library. It computes a fixed-point log2 of an unsigned integer using a single-cycle leading-one encode followed by one fractional bit per cycle via repeated squaring of the normalized mantissa. It uses the same go/done handshake as the other multi-cycle unsigned primitives, so Calyx control can invoke it like std_div_pipe.

---
 rtl/std_log2_pkg.sv | 18 +
 rtl/std_lead_one_enc.sv | 27 ++
 rtl/std_log2_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/std_log2_pkg.sv
// std_log2_pkg
//   Shared types and helpers for the unsigned log2 primitive.
//   state_t : FSM encoding for std_log2_pipe (IDLE, FRAC, DONE).
//   int_w() : width of the integer part of log2 for a given operand width.
package std_log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FRAC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold an MSB index for a width-bit operand (at least 1).
  function automatic int unsigned int_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/std_lead_one_enc.sv
// std_lead_one_enc
//   Combinational priority encoder: index of the most significant set bit.
//   in    : operand
//   idx   : MSB index (0 when in == 0)
//   valid : in != 0
module std_lead_one_enc
  import std_log2_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0]        in,
  output logic [int_w(width)-1:0] idx,
  output logic                    valid
);

  localparam int unsigned IDX_W = int_w(width);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < width; i++) begin
      if (in[i]) idx = IDX_W'(i);
    end
    valid = |in;
  end

endmodule

// File: rtl/std_log2_pipe.sv
// std_log2_pipe
//   Multi-cycle unsigned fixed-point log2 with go/done handshake.
//   Integer part from a leading-one encode, then one fraction bit per cycle
//   by repeated squaring of the normalized mantissa (truncating).
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   go    : level request, held until done
//   in    : unsigned operand, sampled on the IDLE->FRAC edge
//   out   : zero-extended result, {int part, frac_width fraction bits}
//   done  : one-cycle completion pulse
module std_log2_pipe
  import std_log2_pkg::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned frac_width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] in,
  output logic [width-1:0] out,
  output logic             done
);

  localparam int unsigned INT_W = int_w(width);
  localparam int unsigned CNT_W = (frac_width > 1) ? $clog2(frac_width) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(frac_width - 1);

  state_t                  state;
  logic [width-1:0]        m;
  logic [CNT_W-1:0]        cnt;
  logic [frac_width-1:0]   frac;
  logic [INT_W-1:0]        e;

  logic [INT_W-1:0]        lead_idx;
  logic                    lead_valid;
  logic [INT_W-1:0]        shamt;
  logic [2*width-1:0]      sq;
  logic                    frac_bit;
  logic [width-1:0]        m_next;
  logic [frac_width-1:0]   frac_next;
  logic [width-1:0]        result;
  logic                    unused_sq_lsbs;

  std_lead_one_enc #(
    .width(width)
  ) u_enc (
    .in   (in),
    .idx  (lead_idx),
    .valid(lead_valid)
  );

  // Left shift that puts the leading one at bit width-1 (Q1.(width-1)).
  assign shamt = INT_W'(width - 1) - lead_idx;

  // m in [1,2) so sq in [1,4); its top bit says whether sq >= 2.
  assign sq        = {{width{1'b0}}, m} * {{width{1'b0}}, m};
  assign frac_bit  = sq[2*width-1];
  assign m_next    = frac_bit ? sq[2*width-1:width] : sq[2*width-2:width-1];
  assign frac_next = (frac << 1) | frac_width'(frac_bit);
  assign unused_sq_lsbs = ^sq[width-2:0];

  always_comb begin
    result = '0;
    result[INT_W+frac_width-1:frac_width] = e;
    result[frac_width-1:0] = frac_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      out   <= '0;
      done  <= 1'b0;
      m     <= '0;
      cnt   <= '0;
      frac  <= '0;
      e     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            if (lead_valid) begin
              e     <= lead_idx;
              m     <= in << shamt;
              frac  <= '0;
              cnt   <= '0;
              state <= FRAC;
            end else begin
              out   <= '0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FRAC: begin
          if (!go) begin
            state <= IDLE;
          end else begin
            m    <= m_next;
            frac <= frac_next;
            if (cnt == CNT_LAST) begin
              out   <= result;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
